// File: rtl/fb_pkg.sv
// fb_pkg: shared constants for the framebuffer writer and its pixel FIFO.
package fb_pkg;

  localparam int FB_ADDR_W = 15;
  localparam int FB_LAST   = 16383;

  // Pixel byte is {2'b0, R[1:0], G[1:0], B[1:0]} and sits in the low byte of a host word
  localparam int PIX_LSB = 0;
  localparam int PIX_W   = 8;

  // Writer state encoding
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_CLEAR_PEND = 2'd1;
  localparam logic [1:0] ST_CLEAR      = 2'd2;

endpackage

// File: rtl/fb_fifo.sv
// fb_fifo: shift-style synchronous FIFO; slot 0 is always the registered head.
module fb_fifo #(
  parameter  int WIDTH = 23,
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;
  logic [IDX_W-1:0] wr_idx_s;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign count_o = count_q;
  assign head_o  = mem_q[0];

  // Qualify requests, pick the landing slot after any shift, and track occupancy
  always_comb begin
    do_push_s = push_i && !full_o;
    do_pop_s  = pop_i && !empty_o;
    if (do_pop_s) begin
      wr_idx_s = IDX_W'(count_q - CNT_W'(1));
    end else begin
      wr_idx_s = IDX_W'(count_q);
    end
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop_s && !do_push_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Storage: a pop shifts every entry one slot toward the head, a push fills the first free slot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      count_q <= count_d;
      if (do_pop_s) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem_q[i] <= mem_q[i+1];
        end
      end
      if (do_push_s) begin
        mem_q[wr_idx_s] <= data_i;
      end
    end
  end

endmodule

// File: rtl/fb_writer.sv
// fb_writer: host pixel loader that commits framebuffer writes only while the display blanks,
// and can fill the whole framebuffer with a latched colour.
module fb_writer #(
  parameter int FB_ADDR_W  = 15,
  parameter int FB_LAST    = 16383,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clkin,
  input  logic                          nreset,
  input  logic                          blank_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_is_addr,
  input  logic [FB_ADDR_W-1:0]          in_data,
  input  logic                          clear_req,
  input  logic [7:0]                    clear_colour,
  output logic                          fb_we,
  output logic [FB_ADDR_W-1:0]          fb_waddr,
  output logic [7:0]                    fb_wdata,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  import fb_pkg::*;

  localparam int ENT_W = FB_ADDR_W + PIX_W;
  localparam logic [FB_ADDR_W-1:0] LAST_A = FB_ADDR_W'(FB_LAST);

  logic [1:0]           state_q, state_d;
  logic [FB_ADDR_W-1:0] ptr_q, ptr_d;
  logic [FB_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [PIX_W-1:0]     colour_q, colour_d;
  logic                 rdy_en_q;
  logic [ENT_W-1:0]     head_s, entry_s;
  logic                 full_s, empty_s;
  logic                 accept_s, push_s, pop_s, in_clear_s;

  assign in_clear_s = (state_q == ST_CLEAR);
  assign in_ready   = rdy_en_q && !full_s && (state_q == ST_IDLE);
  assign accept_s   = in_valid && in_ready;
  assign push_s     = accept_s && !in_is_addr;
  assign entry_s    = {ptr_q, in_data[PIX_LSB +: PIX_W]};

  // Writes depend only on blank and registered state so they can never land in active video
  assign fb_we    = in_clear_s ? blank_in : (blank_in && !empty_s);
  assign pop_s    = fb_we && !in_clear_s;
  assign fb_waddr = in_clear_s ? clr_cnt_q : head_s[ENT_W-1 -: FB_ADDR_W];
  assign fb_wdata = in_clear_s ? colour_q : head_s[PIX_W-1:0];
  assign busy     = !empty_s || (state_q != ST_IDLE);

  fb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clkin),
    .rst_ni  (nreset),
    .push_i  (push_s),
    .data_i  (entry_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (fifo_count)
  );

  // Next-state logic for the pointer, clear sequencing and colour latch
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    clr_cnt_d = clr_cnt_q;
    colour_d  = colour_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && in_is_addr) begin
          ptr_d = in_data & LAST_A;
        end else if (push_s) begin
          ptr_d = (ptr_q == LAST_A) ? {FB_ADDR_W{1'b0}} : ptr_q + FB_ADDR_W'(1);
        end else begin
          ptr_d = ptr_q;
        end
        if (clear_req) begin
          state_d = ST_CLEAR_PEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR_PEND: begin
        // Queued pixels must land before the fill starts, otherwise they would survive the clear
        if (empty_s) begin
          state_d   = ST_CLEAR;
          colour_d  = clear_colour;
          clr_cnt_d = {FB_ADDR_W{1'b0}};
        end else begin
          state_d = ST_CLEAR_PEND;
        end
      end
      ST_CLEAR: begin
        if (blank_in) begin
          if (clr_cnt_q == LAST_A) begin
            state_d   = ST_IDLE;
            ptr_d     = {FB_ADDR_W{1'b0}};
            clr_cnt_d = {FB_ADDR_W{1'b0}};
          end else begin
            clr_cnt_d = clr_cnt_q + FB_ADDR_W'(1);
          end
        end else begin
          clr_cnt_d = clr_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clkin or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= {FB_ADDR_W{1'b0}};
      clr_cnt_q <= {FB_ADDR_W{1'b0}};
      colour_q  <= {PIX_W{1'b0}};
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      clr_cnt_q <= clr_cnt_d;
      colour_q  <= colour_d;
    end
  end

  // Hold off the host until the first clock edge after reset release
  always_ff @(posedge clkin or negedge nreset) begin
    if (!nreset) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// tb_fb_writer: randomized scenarios checked against a queue-based model of the writer.
module tb_fb_writer;

  localparam int LAST  = 16383;
  localparam int DEPTH = 16;

  logic        clkin = 1'b0;
  logic        nreset = 1'b1;
  logic        blank_in = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_is_addr = 1'b0;
  logic [14:0] in_data = 15'd0;
  logic        clear_req = 1'b0;
  logic [7:0]  clear_colour = 8'd0;
  logic        in_ready, fb_we, busy;
  logic [14:0] fb_waddr;
  logic [7:0]  fb_wdata;
  logic [4:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  // model state
  int m_fifo[$];
  int m_ptr, m_mode, m_clr, m_colour;
  bit m_rdy, m_acc;
  int exp_w[$], obs_w[$], obs_c[$];
  int cyc = 0;
  int mon_bad = 0;

  fb_writer dut (
    .clkin        (clkin),
    .nreset       (nreset),
    .blank_in     (blank_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_is_addr   (in_is_addr),
    .in_data      (in_data),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .fb_we        (fb_we),
    .fb_waddr     (fb_waddr),
    .fb_wdata     (fb_wdata),
    .busy         (busy),
    .fifo_count   (fifo_count)
  );

  always #5 clkin = ~clkin;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_model();
    m_fifo.delete();
    m_ptr = 0; m_mode = 0; m_clr = 0; m_colour = 0;
    m_rdy = 1'b0; m_acc = 1'b0;
  endtask

  task automatic clear_lists();
    exp_w.delete(); obs_w.delete(); obs_c.delete();
    mon_bad = 0;
  endtask

  // One clock: observe at the falling edge, then advance the model at the rising edge.
  task automatic tick();
    int sz, ea, ed;
    bit exp_rdy, exp_we, exp_busy;
    #4;
    sz = m_fifo.size();
    exp_rdy  = m_rdy && (sz < DEPTH) && (m_mode == 0);
    exp_we   = (m_mode == 2) ? blank_in : (blank_in && sz > 0);
    exp_busy = (sz > 0) || (m_mode != 0);
    ea = 0; ed = 0;
    if (m_mode == 2) begin
      ea = m_clr; ed = m_colour;
    end else if (sz > 0) begin
      ea = m_fifo[0] >> 8; ed = m_fifo[0] & 255;
    end
    if (in_ready !== exp_rdy || fb_we !== exp_we || fifo_count !== 5'(sz) || busy !== exp_busy) begin
      mon_bad++;
      if (mon_bad <= 5)
        $display("monitor cycle %0d: in_ready=%b want %b, fb_we=%b want %b, count=%0d want %0d, busy=%b want %b",
                 cyc, in_ready, exp_rdy, fb_we, exp_we, fifo_count, sz, busy, exp_busy);
    end
    if (exp_we) exp_w.push_back((ea << 8) | ed);
    if (fb_we === 1'b1) begin
      obs_w.push_back(int'({fb_waddr, fb_wdata}));
      obs_c.push_back(cyc);
    end
    @(posedge clkin);
    m_acc = in_valid && exp_rdy;
    if (exp_we && m_mode != 2) void'(m_fifo.pop_front());
    case (m_mode)
      0: begin
        if (m_acc) begin
          if (in_is_addr) m_ptr = int'(in_data) & LAST;
          else begin
            m_fifo.push_back((m_ptr << 8) | int'(in_data[7:0]));
            m_ptr = (m_ptr + 1) % (LAST + 1);
          end
        end
        if (clear_req) m_mode = 1;
      end
      1: if (sz == 0) begin m_mode = 2; m_clr = 0; m_colour = int'(clear_colour); end
      2: if (blank_in) begin
        if (m_clr == LAST) begin m_mode = 0; m_ptr = 0; end
        else m_clr++;
      end
      default: m_mode = 0;
    endcase
    m_rdy = 1'b1;
    cyc++;
    #1;
  endtask

  task automatic send(input bit is_addr, input int data);
    in_valid = 1'b1; in_is_addr = is_addr; in_data = 15'(data);
    m_acc = 1'b0;
    for (int k = 0; k < 100 && !m_acc; k++) tick();
    in_valid = 1'b0;
    checks++;
    if (!m_acc) begin
      errors++;
      $display("FAIL send_timeout: word 0x%0h not accepted within 100 cycles", data);
    end
  endtask

  task automatic drain();
    blank_in = 1'b1;
    for (int k = 0; k < 40 && m_fifo.size() > 0; k++) tick();
    tick();
    blank_in = 1'b0;
  endtask

  function automatic int lists_diff();
    int n = 0;
    if (exp_w.size() != obs_w.size()) n++;
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
      if (exp_w[i] != obs_w[i]) n++;
    return n;
  endfunction

  function automatic int obs_at(input int i);
    return (i < obs_w.size()) ? obs_w[i] : -1;
  endfunction

  task automatic test_reset();
    blank_in = 1'b1;
    #1 nreset = 1'b0;
    reset_model();
    clear_lists();
    repeat (2) @(posedge clkin);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we: got %b want 0", fb_we); end
    checks++; if (fb_waddr !== 15'd0 || fb_wdata !== 8'd0) begin errors++; $display("FAIL reset_addr_data: got %h/%h want 0/0", fb_waddr, fb_wdata); end
    checks++; if (busy !== 1'b0 || fifo_count !== 5'd0) begin errors++; $display("FAIL reset_busy_count: got %b/%0d want 0/0", busy, fifo_count); end
    nreset = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    blank_in = 1'b0;
  endtask

  task automatic test_basic_write();
    clear_lists();
    blank_in = 1'b1;
    send(1'b1, 'h0100);
    send(1'b0, 'h15);
    send(1'b0, 'h2A);
    repeat (3) tick();
    checks++; if (obs_w.size() !== 2) begin errors++; $display("FAIL basic_count: got %0d writes want 2", obs_w.size()); end
    checks++; if (obs_at(0) !== 'h010015 || obs_at(1) !== 'h01012A) begin errors++; $display("FAIL basic_data: got %h,%h want 010015,01012a", obs_at(0), obs_at(1)); end
    checks++; if (obs_c.size() != 2 || obs_c[1] - obs_c[0] !== 1) begin errors++; $display("FAIL basic_consecutive: writes not on consecutive cycles (%0d writes)", obs_c.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy); end
    checks++; if (lists_diff() !== 0 || mon_bad !== 0) begin errors++; $display("FAIL basic_model: diff=%0d monitor=%0d want 0/0", lists_diff(), mon_bad); end
    blank_in = 1'b0;
  endtask

  task automatic test_blank_gating();
    clear_lists();
    blank_in = 1'b0;
    send(1'b1, int'($urandom_range(0, 'h3000)));
    repeat (4) send(1'b0, int'($urandom_range(0, 255)));
    tick();
    checks++; if (fifo_count !== 5'd4 || obs_w.size() !== 0) begin errors++; $display("FAIL gate_hold: count=%0d writes=%0d want 4/0", fifo_count, obs_w.size()); end
    blank_in = 1'b1;
    tick(); tick();
    blank_in = 1'b0;
    checks++; if (fifo_count !== 5'd2 || obs_w.size() !== 2) begin errors++; $display("FAIL gate_two: count=%0d writes=%0d want 2/2", fifo_count, obs_w.size()); end
    repeat (3) tick();
    checks++; if (obs_w.size() !== 2 || fifo_count !== 5'd2) begin errors++; $display("FAIL gate_after_fall: writes=%0d count=%0d want 2/2", obs_w.size(), fifo_count); end
    drain();
    checks++; if (lists_diff() !== 0 || mon_bad !== 0) begin errors++; $display("FAIL gate_model: diff=%0d monitor=%0d want 0/0", lists_diff(), mon_bad); end
  endtask

  task automatic test_full();
    int last_px;
    clear_lists();
    blank_in = 1'b0;
    send(1'b1, int'($urandom_range(0, 'h3000)));
    repeat (16) send(1'b0, int'($urandom_range(0, 255)));
    last_px = int'($urandom_range(0, 255));
    in_valid = 1'b1; in_is_addr = 1'b0; in_data = 15'(last_px);
    tick();
    checks++; if (in_ready !== 1'b0 || fifo_count !== 5'd16) begin errors++; $display("FAIL full_hold: ready=%b count=%0d want 0/16", in_ready, fifo_count); end
    blank_in = 1'b1;
    tick();
    blank_in = 1'b0;
    checks++; if (fifo_count !== 5'd15 || in_ready !== 1'b1 || obs_w.size() !== 1) begin errors++; $display("FAIL full_pop: count=%0d ready=%b writes=%0d want 15/1/1", fifo_count, in_ready, obs_w.size()); end
    tick();
    in_valid = 1'b0;
    checks++; if (fifo_count !== 5'd16 || in_ready !== 1'b0) begin errors++; $display("FAIL full_accept17: count=%0d ready=%b want 16/0", fifo_count, in_ready); end
    drain();
    checks++; if (obs_w.size() != 17 || (obs_at(16) & 255) !== last_px) begin errors++; $display("FAIL full_last: writes=%0d last=%h want 17/%h", obs_w.size(), obs_at(16) & 255, last_px); end
    checks++; if (lists_diff() !== 0 || mon_bad !== 0) begin errors++; $display("FAIL full_model: diff=%0d monitor=%0d want 0/0", lists_diff(), mon_bad); end
  endtask

  task automatic test_pointer_wrap();
    clear_lists();
    blank_in = 1'b1;
    send(1'b1, 'h3FFF);
    send(1'b0, 'h01);
    send(1'b0, 'h02);
    repeat (3) tick();
    blank_in = 1'b0;
    checks++; if (obs_w.size() !== 2 || obs_at(0) !== 'h3FFF01 || obs_at(1) !== 'h000002) begin errors++; $display("FAIL wrap: got %0d writes %h,%h want 3fff01,000002", obs_w.size(), obs_at(0), obs_at(1)); end
  endtask

  task automatic test_random();
    clear_lists();
    for (int k = 0; k < 400; k++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_is_addr = ($urandom_range(0, 7) == 0);
      in_data    = 15'($urandom);
      blank_in   = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    drain();
    checks++; if (lists_diff() !== 0 || mon_bad !== 0) begin errors++; $display("FAIL random_model: diff=%0d monitor=%0d want 0/0", lists_diff(), mon_bad); end
    checks++; if (busy !== 1'b0 || fifo_count !== 5'd0) begin errors++; $display("FAIL random_idle: busy=%b count=%0d want 0/0", busy, fifo_count); end
  endtask

  task automatic test_clear();
    int px[3];
    int n, bad;
    clear_lists();
    blank_in = 1'b0;
    send(1'b1, 'h1234);
    for (int i = 0; i < 3; i++) begin
      px[i] = int'($urandom_range(0, 255));
      send(1'b0, px[i]);
    end
    clear_colour = 8'h3F; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL clear_pend: ready=%b busy=%b want 0/1", in_ready, busy); end
    n = 0;
    while (m_mode != 0 && n < 40000) begin
      blank_in = ($urandom_range(0, 3) != 0);
      if (m_mode == 2) clear_colour = 8'h00;
      tick();
      n++;
    end
    blank_in = 1'b0;
    checks++; if (n >= 40000) begin errors++; $display("FAIL clear_timeout: clear did not finish in %0d cycles", n); end
    checks++; if (obs_w.size() !== 16387) begin errors++; $display("FAIL clear_count: got %0d writes want 16387", obs_w.size()); end
    checks++; if (obs_at(0) !== (('h1234 << 8) | px[0]) || obs_at(1) !== (('h1235 << 8) | px[1]) || obs_at(2) !== (('h1236 << 8) | px[2])) begin
      errors++; $display("FAIL clear_pixels_first: got %h,%h,%h", obs_at(0), obs_at(1), obs_at(2));
    end
    bad = 0;
    for (int i = 0; i <= LAST; i++) if (obs_at(3 + i) !== ((i << 8) | 'h3F)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL clear_fill: %0d fill writes wrong, want 0", bad); end
    checks++; if (lists_diff() !== 0 || mon_bad !== 0) begin errors++; $display("FAIL clear_model: diff=%0d monitor=%0d want 0/0", lists_diff(), mon_bad); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL clear_exit: ready=%b busy=%b want 1/0", in_ready, busy); end
    blank_in = 1'b1;
    send(1'b0, 'h2A);
    repeat (2) tick();
    blank_in = 1'b0;
    checks++; if (obs_at(obs_w.size() - 1) !== 'h00002A) begin errors++; $display("FAIL clear_ptr_zero: last write %h want 00002a", obs_at(obs_w.size() - 1)); end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    clear_lists();
    blank_in = 1'b1;
    clear_colour = 8'($urandom);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n = 0;
    while (!(m_mode == 2 && m_clr == 'h0800) && n < 5000) begin tick(); n++; end
    checks++; if (n >= 5000) begin errors++; $display("FAIL midclear_timeout: clear did not reach 0x0800"); end
    checks++; if (fb_we !== 1'b1 || fb_waddr !== 15'h0800) begin errors++; $display("FAIL midclear_addr: we=%b addr=%h want 1/0800", fb_we, fb_waddr); end
    checks++; if (lists_diff() !== 0 || mon_bad !== 0) begin errors++; $display("FAIL midclear_model: diff=%0d monitor=%0d want 0/0", lists_diff(), mon_bad); end
    nreset = 1'b0;
    #1;
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL midclear_async_we: got %b want 0", fb_we); end
    #1;
    checks++; if (in_ready !== 1'b0 || fb_waddr !== 15'd0 || fb_wdata !== 8'd0 || busy !== 1'b0 || fifo_count !== 5'd0) begin
      errors++; $display("FAIL midclear_in_reset: ready=%b addr=%h data=%h busy=%b count=%0d want all 0", in_ready, fb_waddr, fb_wdata, busy, fifo_count);
    end
    reset_model();
    clear_lists();
    @(posedge clkin);
    #1;
    nreset = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || fb_we !== 1'b0 || busy !== 1'b0 || fifo_count !== 5'd0 || fb_waddr !== 15'd0 || fb_wdata !== 8'd0) begin
      errors++; $display("FAIL midclear_release: ready=%b we=%b busy=%b count=%0d addr=%h data=%h", in_ready, fb_we, busy, fifo_count, fb_waddr, fb_wdata);
    end
    blank_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_blank_gating();
    test_full();
    test_pointer_wrap();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
